// File: rtl/ipif_regbank_pkg.sv
// Shared types and helpers for the IPIF register bank: per-bit access classes
// and counter sizing.
package ipif_regbank_pkg;

    typedef enum logic [1:0] {
        CLS_RW,
        CLS_RO,
        CLS_W1C,
        CLS_PULSE
    } bit_class_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // When masks overlap: PULSE > W1C > RW > RO.
    function automatic bit_class_t resolve_class(input logic rw, input logic w1c, input logic pulse);
        if (pulse) return CLS_PULSE;
        if (w1c)   return CLS_W1C;
        if (rw)    return CLS_RW;
        return CLS_RO;
    endfunction

endpackage

// File: rtl/ipif_pulse_stretch.sv
// One register's self-clearing pulse bits. Each set event ORs in new bits and
// reloads a shared down-counter; every bit of the register drops together when it expires.
module ipif_pulse_stretch
    import ipif_regbank_pkg::*;
#(
    parameter int W         = 32,
    parameter int PULSE_LEN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] set_bits,
    output logic [W-1:0] pulse
);

    localparam int            CW   = cnt_width(PULSE_LEN);
    localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            pulse <= '0;
        end else if (|set_bits) begin
            pulse <= pulse | set_bits;
            cnt   <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) pulse <= '0;
        end
    end

endmodule

// File: rtl/ipif_register_bank.sv
// IPIF-side register bank: N_REG words with byte-lane writes and per-bit RW / RO /
// W1C-sticky / self-clearing pulse classes. Reads are captured in the request cycle.
module ipif_register_bank
    import ipif_regbank_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int N_REG              = 8,
    parameter int USE_ONEHOT         = 1,
    parameter int READ_PIPE          = 1,
    parameter int PULSE_LEN          = 1,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] DEFAULTS   = '0,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] RW_MASK    = '1,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] W1C_MASK   = '0,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] PULSE_MASK = '0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]         IPIF_bus2ip_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         IPIF_bus2ip_data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       IPIF_bus2ip_be,
    input  logic [N_REG-1:0]                      IPIF_bus2ip_rdce,
    input  logic [N_REG-1:0]                      IPIF_bus2ip_wrce,
    input  logic                                  IPIF_bus2ip_rdreq,
    input  logic                                  IPIF_bus2ip_wrreq,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         IPIF_ip2bus_data,
    output logic                                  IPIF_ip2bus_rdack,
    output logic                                  IPIF_ip2bus_wrack,
    output logic                                  IPIF_ip2bus_error,
    output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   regs_out,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   status_in,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   status_set
);

    localparam int W     = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int NB    = W / 8;
    localparam int TOT   = N_REG * W;
    localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;

    function automatic logic [TOT-1:0] class_bits(input bit_class_t c);
        logic [TOT-1:0] v;
        for (int i = 0; i < TOT; i++)
            v[i] = (resolve_class(RW_MASK[i], W1C_MASK[i], PULSE_MASK[i]) == c);
        return v;
    endfunction

    localparam logic [TOT-1:0] RW_BITS    = class_bits(CLS_RW);
    localparam logic [TOT-1:0] RO_BITS    = class_bits(CLS_RO);
    localparam logic [TOT-1:0] W1C_BITS   = class_bits(CLS_W1C);
    localparam logic [TOT-1:0] PULSE_BITS = class_bits(CLS_PULSE);

    logic [AW-1:0]    word_addr;
    logic             addr_ok;
    logic [IDX_W-1:0] addr_idx;
    logic             unused_addr;

    assign word_addr   = {2'b00, IPIF_bus2ip_addr[AW-1:2]};
    assign addr_ok     = (word_addr < AW'(N_REG));
    assign addr_idx    = word_addr[IDX_W-1:0];
    assign unused_addr = ^IPIF_bus2ip_addr[1:0];

    logic [N_REG-1:0] wr_sel;
    logic             wr_strobe, wr_err, rd_strobe, rd_err;
    logic [IDX_W-1:0] rd_idx;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_sel    = '0;
        wr_strobe = 1'b0;
        wr_err    = 1'b0;
        rd_strobe = 1'b0;
        rd_err    = 1'b0;
        rd_idx    = '0;
        if (USE_ONEHOT != 0) begin
            wr_sel    = IPIF_bus2ip_wrce;
            wr_strobe = |IPIF_bus2ip_wrce;
            rd_strobe = |IPIF_bus2ip_rdce;
            for (int i = 0; i < N_REG; i++)
                if (IPIF_bus2ip_rdce[i]) rd_idx = IDX_W'(i);
        end else begin
            wr_strobe = IPIF_bus2ip_wrreq;
            wr_err    = IPIF_bus2ip_wrreq & ~addr_ok;
            rd_strobe = IPIF_bus2ip_rdreq;
            rd_err    = IPIF_bus2ip_rdreq & ~addr_ok;
            rd_idx    = addr_idx;
            if (IPIF_bus2ip_wrreq && addr_ok) wr_sel[addr_idx] = 1'b1;
        end
    end

    // Per-bit write enable: register selected and its byte lane enabled.
    logic [W-1:0]   be_bits;
    logic [TOT-1:0] wr_en, data_rep;

    always_comb begin
        be_bits = '0;
        wr_en   = '0;
        for (int k = 0; k < NB; k++) be_bits[k*8 +: 8] = {8{IPIF_bus2ip_be[k]}};
        for (int r = 0; r < N_REG; r++) wr_en[r*W +: W] = wr_sel[r] ? be_bits : '0;
    end

    assign data_rep = {N_REG{IPIF_bus2ip_data}};

    logic [TOT-1:0] rw_q, sticky_q, pulse_flat;

    // status_set is ORed in after the clear, so a same-cycle set beats a write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q     <= DEFAULTS & RW_BITS;
            sticky_q <= '0;
        end else begin
            rw_q     <= (rw_q & ~(wr_en & RW_BITS)) | (data_rep & wr_en & RW_BITS);
            sticky_q <= ((sticky_q & ~(wr_en & data_rep)) | status_set) & W1C_BITS;
        end
    end

    for (genvar r = 0; r < N_REG; r++) begin : g_pulse
        ipif_pulse_stretch #(
            .W         (W),
            .PULSE_LEN (PULSE_LEN)
        ) u_pulse (
            .clk      (clk),
            .rst      (rst),
            .set_bits (wr_en[r*W +: W] & IPIF_bus2ip_data & PULSE_BITS[r*W +: W]),
            .pulse    (pulse_flat[r*W +: W])
        );
    end

    logic [TOT-1:0] live_flat;
    logic [W-1:0]   rd_word;

    assign live_flat = (rw_q & RW_BITS) | (pulse_flat & PULSE_BITS) | sticky_q | (status_in & RO_BITS);

    always_comb begin
        rd_word = '0;
        for (int r = 0; r < N_REG; r++)
            if (rd_idx == IDX_W'(r)) rd_word = live_flat[r*W +: W];
    end

    logic         s1_ack, s1_err, wr_ack_q, wr_err_q, rd_err_out;
    logic [W-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_ack   <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            s1_ack   <= rd_strobe;
            s1_err   <= rd_err;
            s1_data  <= (rd_strobe && !rd_err) ? rd_word : '0;
            wr_ack_q <= wr_strobe;
            wr_err_q <= wr_err;
        end
    end

    if (READ_PIPE == 2) begin : g_pipe2
        logic         s2_ack, s2_err;
        logic [W-1:0] s2_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_ack  <= 1'b0;
                s2_err  <= 1'b0;
                s2_data <= '0;
            end else begin
                s2_ack  <= s1_ack;
                s2_err  <= s1_err;
                s2_data <= s1_data;
            end
        end

        assign IPIF_ip2bus_rdack = s2_ack;
        assign IPIF_ip2bus_data  = s2_data;
        assign rd_err_out        = s2_err;
    end else begin : g_pipe1
        assign IPIF_ip2bus_rdack = s1_ack;
        assign IPIF_ip2bus_data  = s1_data;
        assign rd_err_out        = s1_err;
    end

    assign IPIF_ip2bus_wrack = wr_ack_q;
    assign IPIF_ip2bus_error = rd_err_out | wr_err_q;

    // Register contents are visible here from reset onwards, so regs_out carries DEFAULTS in reset.
    assign regs_out = (rw_q & RW_BITS) | (pulse_flat & PULSE_BITS);

endmodule

// File: tb/tb_ipif_register_bank.sv
// Directed bench: DUT A decodes addresses (READ_PIPE=1, PULSE_LEN=4),
// DUT B decodes one-hot chip enables (READ_PIPE=2).
module tb_ipif_register_bank;

    localparam int W   = 32;
    localparam int NR  = 8;
    localparam int TOT = NR * W;

    localparam logic [TOT-1:0] DEF  = {224'h0, 32'h12345678};
    localparam logic [TOT-1:0] RO_M = 256'hFFFF << 96;
    localparam logic [TOT-1:0] RWM  = ~RO_M;
    localparam logic [TOT-1:0] W1CM = 256'hFF << 32;
    localparam logic [TOT-1:0] PM   = 256'h1 << 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [TOT-1:0] st_in = 256'hBEEF << 96;

    // DUT A signals
    logic [31:0]    a_addr = '0, a_data = '0;
    logic [3:0]     a_be = '0;
    logic           a_rdreq = 1'b0, a_wrreq = 1'b0;
    logic [NR-1:0]  a_rdce = '0, a_wrce = '0;
    logic [TOT-1:0] a_set = '0;
    logic [31:0]    a_rdata;
    logic           a_rdack, a_wrack, a_err;
    logic [TOT-1:0] a_regs;

    // DUT B signals
    logic [31:0]    b_addr = '0, b_data = '0;
    logic [3:0]     b_be = '0;
    logic           b_rdreq = 1'b0, b_wrreq = 1'b0;
    logic [NR-1:0]  b_rdce = '0, b_wrce = '0;
    logic [TOT-1:0] b_set = '0;
    logic [31:0]    b_rdata;
    logic           b_rdack, b_wrack, b_err;
    logic [TOT-1:0] b_regs;

    ipif_register_bank #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .N_REG(NR),
        .USE_ONEHOT(0), .READ_PIPE(1), .PULSE_LEN(4),
        .DEFAULTS(DEF), .RW_MASK(RWM), .W1C_MASK(W1CM), .PULSE_MASK(PM)
    ) dut_a (
        .clk(clk), .rst(rst),
        .IPIF_bus2ip_addr(a_addr), .IPIF_bus2ip_data(a_data), .IPIF_bus2ip_be(a_be),
        .IPIF_bus2ip_rdce(a_rdce), .IPIF_bus2ip_wrce(a_wrce),
        .IPIF_bus2ip_rdreq(a_rdreq), .IPIF_bus2ip_wrreq(a_wrreq),
        .IPIF_ip2bus_data(a_rdata), .IPIF_ip2bus_rdack(a_rdack),
        .IPIF_ip2bus_wrack(a_wrack), .IPIF_ip2bus_error(a_err),
        .regs_out(a_regs), .status_in(st_in), .status_set(a_set)
    );

    ipif_register_bank #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .N_REG(NR),
        .USE_ONEHOT(1), .READ_PIPE(2), .PULSE_LEN(1),
        .DEFAULTS(DEF), .RW_MASK(RWM), .W1C_MASK(W1CM), .PULSE_MASK(PM)
    ) dut_b (
        .clk(clk), .rst(rst),
        .IPIF_bus2ip_addr(b_addr), .IPIF_bus2ip_data(b_data), .IPIF_bus2ip_be(b_be),
        .IPIF_bus2ip_rdce(b_rdce), .IPIF_bus2ip_wrce(b_wrce),
        .IPIF_bus2ip_rdreq(b_rdreq), .IPIF_bus2ip_wrreq(b_wrreq),
        .IPIF_ip2bus_data(b_rdata), .IPIF_ip2bus_rdack(b_rdack),
        .IPIF_ip2bus_wrack(b_wrack), .IPIF_ip2bus_error(b_err),
        .regs_out(b_regs), .status_in(st_in), .status_set(b_set)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    // One address-mode access on DUT A; samples the ack cycle and the cycle after.
    task automatic a_op(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, output logic ack, output logic err,
                        output logic [31:0] rdata, output logic [32:0] idle);
        @(negedge clk);
        a_addr = addr; a_data = data; a_be = be;
        if (wr) a_wrreq = 1'b1; else a_rdreq = 1'b1;
        @(negedge clk);
        a_wrreq = 1'b0; a_rdreq = 1'b0;
        ack   = wr ? a_wrack : a_rdack;
        err   = a_err;
        rdata = a_rdata;
        @(negedge clk);
        idle = {a_rdack | a_wrack, a_rdata};
    endtask

    task automatic a_read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic ack, err;
        logic [31:0] d;
        logic [32:0] idle;
        a_op(1'b0, addr, 32'h0, 4'h0, ack, err, d, idle);
        check({name, " rdack"}, TOT'(ack), TOT'(1'b1));
        check({name, " data"}, TOT'(d), TOT'(exp));
    endtask

    task automatic b_write(input logic [NR-1:0] wrce, input logic [31:0] data);
        @(negedge clk);
        b_wrce = wrce; b_data = data; b_be = 4'hF;
        @(negedge clk);
        b_wrce = '0;
        check("b write wrack", TOT'({b_wrack, b_err}), TOT'(2'b10));
        @(negedge clk);
        check("b write wrack single", TOT'(b_wrack), TOT'(1'b0));
    endtask

    task automatic b_read(input string name, input logic [NR-1:0] rdce, input logic [31:0] exp);
        @(negedge clk);
        b_rdce = rdce;
        @(negedge clk);
        b_rdce = '0;
        check({name, " no early rdack"}, TOT'(b_rdack), TOT'(1'b0));
        @(negedge clk);
        check({name, " rdack/err"}, TOT'({b_rdack, b_err}), TOT'(2'b10));
        check({name, " data"}, TOT'(b_rdata), TOT'(exp));
    endtask

    task automatic pulse_run(input int rewrite_c, output int highs, output logic first);
        highs = 0;
        first = 1'b0;
        @(negedge clk);
        a_addr = 32'h08; a_data = 32'h1; a_be = 4'h1; a_wrreq = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            a_wrreq = (c == rewrite_c);
            if (a_regs[64]) highs++;
            if (c == 0) first = a_regs[64];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack, err, first;
        logic [31:0] d;
        logic [32:0] idle;
        int highs;

        vecs[0]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 32'h00, 32'hAABBCCDD, 4'h5, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h12BB56DD, 1'b0};
        vecs[4]  = '{1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 32'h14, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[6]  = '{1'b0, 32'h20, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 32'h24, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h12BB56DD, 1'b0};
        vecs[9]  = '{1'b0, 32'h1C, 32'h0,        4'h0, 32'h00000000, 1'b0};
        vecs[10] = '{1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'hFFFFBEEF, 1'b0};
        vecs[12] = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b0};
        vecs[13] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hFFFFFF00, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset a bus outputs", TOT'({a_rdack, a_wrack, a_err, a_rdata}), '0);
        check("reset a regs_out", a_regs, DEF);
        check("reset b bus outputs", TOT'({b_rdack, b_wrack, b_err, b_rdata}), '0);
        rst = 1'b0;

        // Table-driven address-mode accesses
        for (int i = 0; i < 14; i++) begin
            a_op(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, ack, err, d, idle);
            check($sformatf("vec%0d ack", i), TOT'(ack), TOT'(1'b1));
            check($sformatf("vec%0d error", i), TOT'(err), TOT'(vecs[i].exp_err));
            check($sformatf("vec%0d data", i), TOT'(d), TOT'(vecs[i].exp_data));
            check($sformatf("vec%0d idle after ack", i), TOT'(idle), '0);
        end
        check("a regs_out after table", a_regs,
              {32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 32'hFFFF0000, 32'h0, 32'hFFFFFF00, 32'h12BB56DD});

        // W1C: set event, clear racing a set, plain clear
        @(negedge clk); a_set[35] = 1'b1;
        @(negedge clk); a_set = '0;
        a_read_check("w1c set", 32'h04, 32'hFFFFFF08);
        @(negedge clk);
        a_set[35] = 1'b1; a_addr = 32'h04; a_data = 32'h08; a_be = 4'h1; a_wrreq = 1'b1;
        @(negedge clk);
        a_set = '0; a_wrreq = 1'b0;
        a_read_check("w1c set beats clear", 32'h04, 32'hFFFFFF08);
        a_op(1'b1, 32'h04, 32'h08, 4'h1, ack, err, d, idle);
        a_read_check("w1c clear", 32'h04, 32'hFFFFFF00);

        // Pulse stretching on reg2 bit0
        pulse_run(-1, highs, first);
        check("pulse high right after write", TOT'(first), TOT'(1'b1));
        check("pulse length 4", TOT'(highs), TOT'(4));
        pulse_run(1, highs, first);
        check("pulse rewrite length 6", TOT'(highs), TOT'(6));

        // One-hot decode, two-stage read pipe
        b_write(8'hA0, 32'h5A5A5A5A);
        b_write(8'h06, 32'h11223344);
        b_read("b rd reg5", 8'h20, 32'h5A5A5A5A);
        b_read("b rd multi 0x81", 8'h81, 32'h5A5A5A5A);
        b_read("b rd multi 0x03", 8'h03, 32'h11223300);
        b_read("b rd reg6 untouched", 8'h40, 32'h00000000);

        // Back-to-back burst
        @(negedge clk); b_rdce = 8'h01;
        @(negedge clk); check("burst no ack at 1", TOT'(b_rdack), TOT'(1'b0)); b_rdce = 8'h02;
        @(negedge clk); check("burst ack0", TOT'({b_rdack, b_rdata}), TOT'({1'b1, 32'h12345678})); b_rdce = 8'h04;
        @(negedge clk); check("burst ack1", TOT'({b_rdack, b_rdata}), TOT'({1'b1, 32'h11223300})); b_rdce = '0;
        @(negedge clk); check("burst ack2", TOT'({b_rdack, b_rdata}), TOT'({1'b1, 32'h11223344}));
        @(negedge clk); check("burst idle", TOT'({b_rdack, b_rdata}), '0);

        // Reset asserted in the middle of a burst
        @(negedge clk); b_rdce = 8'h01;
        @(negedge clk); b_rdce = 8'h02;
        @(negedge clk); b_rdce = 8'h04;
        check("mid-burst ack before reset", TOT'(b_rdack), TOT'(1'b1));
        #1 rst = 1'b1;
        #1;
        check("reset mid-burst b bus outputs", TOT'({b_rdack, b_wrack, b_err, b_rdata}), '0);
        check("reset mid-burst b regs_out", b_regs, DEF);
        check("reset mid-burst a regs_out", a_regs, DEF);
        b_rdce = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        b_read("b rd after reset", 8'h20, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ipif_register_bank.md
Name: ipif_register_bank

Overview:
- Generalised IPIF-side register bank: N_REG registers of C_S_AXI_DATA_WIDTH bits, byte-lane writes, and per-bit access classes (RW, RO, W1C sticky, self-clearing pulse).
- Configurable read pipeline depth and address-error acknowledge.
- Sits between the AXI-Lite→IPIF bridge and firmware control/status logic; replaces ad-hoc per-project parameter decoders.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width; multiple of 8.
- C_S_AXI_ADDR_WIDTH, 32, bus address width (byte address, word index = addr>>2).
- N_REG, 8, number of registers; 1..256.
- USE_ONEHOT, 1, 1 = decode from rdce/wrce; 0 = decode from addr with rdreq/wrreq.
- READ_PIPE, 1, read latency in cycles; 1 or 2.
- PULSE_LEN, 1, cycles a pulse bit stays asserted; ≥1.
- DEFAULTS, all 0, N_REG*W reset values for RW bits.
- RW_MASK, all 1, N_REG*W; 1 = read/write bit.
- W1C_MASK, all 0, N_REG*W; 1 = sticky status bit, write-1-to-clear.
- PULSE_MASK, all 0, N_REG*W; 1 = write-1 self-clearing pulse bit.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- IPIF_bus2ip_addr  in  C_S_AXI_ADDR_WIDTH  byte address.
- IPIF_bus2ip_data  in  C_S_AXI_DATA_WIDTH  write data.
- IPIF_bus2ip_be  in  C_S_AXI_DATA_WIDTH/8  byte enables.
- IPIF_bus2ip_rdce  in  N_REG  one-hot read select (USE_ONEHOT=1).
- IPIF_bus2ip_wrce  in  N_REG  one-hot write select (USE_ONEHOT=1).
- IPIF_bus2ip_rdreq  in  1  single-cycle read strobe (USE_ONEHOT=0).
- IPIF_bus2ip_wrreq  in  1  single-cycle write strobe (USE_ONEHOT=0).
- IPIF_ip2bus_data  out  C_S_AXI_DATA_WIDTH  read data, valid with rdack.
- IPIF_ip2bus_rdack  out  1  read acknowledge pulse.
- IPIF_ip2bus_wrack  out  1  write acknowledge pulse.
- IPIF_ip2bus_error  out  1  qualifies rdack/wrack as address error.
- regs_out  out  N_REG*W  RW bits (register values) and pulse bits (live state); 0 elsewhere.
- status_in  in  N_REG*W  live RO inputs.
- status_set  in  N_REG*W  one-cycle set events for W1C bits.

Behaviour:
- Bit class precedence when masks overlap: PULSE > W1C > RW > RO (RO = no mask bit set).
- Reset (async assert): RW bits ← DEFAULTS; W1C and pulse bits ← 0; pulse counters ← 0; all outputs 0. Deassertion is synchronised upstream.
- Write: byte lane k updated only if be[k]=1.
  - RW bits take data.
  - W1C bits clear where data=1; status_set in the same cycle wins (bit stays 1).
  - Pulse bits set where data=1 and the register's counter loads PULSE_LEN; the counter decrements each cycle and all pulse bits of that register clear when it hits 0.
  - Rewrite during an active pulse ORs the new bits and reloads the counter.
  - RO bits are ignored.
- wrack: exactly one cycle after the write strobe, at most one per strobe.
- Read: word composed per bit as RW → register, pulse → live state, W1C → sticky, RO → status_in.
  - The value is sampled in the request cycle, so a same-cycle write to the same register returns the pre-write value.
  - Data and rdack appear READ_PIPE cycles after the request. With READ_PIPE=2 a second stage register is added; back-to-back requests are accepted every cycle.
- USE_ONEHOT=1: multiple wrce bits write every selected register. Multiple rdce bits read the highest set index. Error is never asserted.
- USE_ONEHOT=0: word index ≥ N_REG produces an ack with error=1 and data 0, with no state change.
- W1C sticky bits set from status_set every cycle regardless of bus activity.
- ip2bus_data returns to 0 on cycles without rdack.

Decomposition:
- Package ipif_regbank_pkg:
  - bit-class enum {RW, RO, W1C, PULSE};
  - clog2-based counter width function;
  - function resolving a per-bit class from the three masks.
- One sub-module, ipif_pulse_stretch: per-register counter plus pulse bits, instantiated N_REG times via generate.

Test Plan:
- Reset → with DEFAULTS reg0=0x12345678 and RW_MASK all 1, read reg0 → rdack after READ_PIPE cycles, data 0x12345678, regs_out[31:0]=0x12345678.
- Write reg0 0xAABBCCDD, be=0b0101 → wrack next cycle, reg0 reads 0x12BB56DD.
- W1C reg1 mask 0xFF: status_set bit3 pulse → read 0x08. Write 0x08 in the same cycle as a new status_set bit3 → read still 0x08. Write 0x08 alone → read 0x00.
- PULSE reg2 bit0, PULSE_LEN=4: write 0x1 → regs_out bit0 high exactly 4 cycles. Rewrite at cycle 2 → high 6 cycles total.
- USE_ONEHOT=0, N_REG=8: read addr 0x20 → rdack with error=1, data 0. Write addr 0x24 → wrack with error=1, no register changes.
- READ_PIPE=2: reads every cycle to regs 0,1,2 → three consecutive rdacks starting 2 cycles after the first request, correct data order. Assert rst mid-burst → all outputs 0 immediately, registers at defaults.
